// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment display blocks.
package seg_pkg;

  localparam int NUM_DIGITS = 8;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef logic [2:0] digit_idx_t;

  // Active-low {g,f,e,d,c,b,a} codes for hex digits 0..F.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational nibble to active-low seven-segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// 8-digit seven-segment scan controller with frame-aligned snapshot of two 16-bit values.
// Optional LEADING_ZERO_BLANK_EN blanks leading zeros of each 4-digit half.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int CLK_DIV = 100000
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [15:0]           val_hi,
  input  logic [15:0]           val_lo,
  input  logic                  freeze,
  output logic [NUM_DIGITS-1:0] en_out,
  output logic [6:0]            out7,
  output logic                  frame_done
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  digit_idx_t            idx_q, idx_d;
  logic [31:0]           snap_q, snap_d;
  logic [NUM_DIGITS-1:0] en_out_q, en_out_d;
  logic [6:0]            out7_q, out7_d;
  logic                  frame_done_q, frame_done_d;

  logic       tc;
  logic       frame_start;
  logic [3:0] cur_nib;
  logic [6:0] cur_seg;

  assign cur_nib = snap_q[{idx_q, 2'b00} +: 4];

  seg_hex_decode u_dec (
    .nib (cur_nib),
    .seg (cur_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  logic [3:0] half_nz;
  logic       blank;

  // A digit is blank when it and every higher digit of its half are zero;
  // the lowest digit of each half always shows.
  always_comb begin
    half_nz = '0;
    for (int i = 0; i < 4; i++) begin
      half_nz[i] = |snap_q[{idx_q[2], i[1:0], 2'b00} +: 4];
    end
    blank = (idx_q[1:0] != 2'b00) && ((half_nz >> idx_q[1:0]) == 4'b0000);
  end
`endif

  always_comb begin
    tc           = (cnt_q == CNT_MAX);
    frame_start  = (idx_q == 3'd0) && (cnt_q == '0);
    cnt_d        = tc ? '0 : cnt_q + 1'b1;
    idx_d        = tc ? idx_q + 3'd1 : idx_q;
    snap_d       = (frame_start && !freeze) ? {val_hi, val_lo} : snap_q;
    en_out_d     = ~(NUM_DIGITS'(1) << idx_q);
`ifdef LEADING_ZERO_BLANK_EN
    out7_d       = blank ? SEG_BLANK : cur_seg;
`else
    out7_d       = cur_seg;
`endif
    frame_done_d = frame_start;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      en_out_q     <= '1;
      out7_q       <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      en_out_q     <= en_out_d;
      out7_q       <= out7_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign en_out     = en_out_q;
  assign out7       = out7_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized scoreboard bench for seg_scan_ctrl with CLK_DIV=4.
module tb_seg_scan_ctrl;

  localparam int DIV   = 4;
  localparam int FRAME = 8 * DIV;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic [15:0] val_hi = '0;
  logic [15:0] val_lo = '0;
  logic        freeze = 1'b0;
  logic [7:0]  en_out;
  logic [6:0]  out7;
  logic        frame_done;

  seg_scan_ctrl #(.CLK_DIV(DIV)) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .val_hi     (val_hi),
    .val_lo     (val_lo),
    .freeze     (freeze),
    .en_out     (en_out),
    .out7       (out7),
    .frame_done (frame_done)
  );

  // clock / reset
  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [15:0] exp_q[$];

  // reference model state: edges since reset release and the displayed snapshot
  int          t_m = 0;
  logic [31:0] snap_m = '0;

  logic [6:0] seg_tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] exp_seg(logic [31:0] s, int d);
    logic [15:0] half;
    int p;
    logic [31:0] sh;
    half = (d >= 4) ? s[31:16] : s[15:0];
    p = d % 4;
    if (LZB && p != 0 && (half >> (4 * p)) == 16'h0) return 7'h7F;
    sh = s >> (4 * d);
    return seg_tbl[sh[3:0]];
  endfunction

  // driver: apply inputs on the falling edge and push the response expected after the next rising edge
  task automatic step(input logic [15:0] hi, input logic [15:0] lo, input logic frz, input logic rst);
    int d;
    logic [7:0] e_en;
    logic [6:0] e_seg;
    logic e_fd;
    @(negedge Clk);
    val_hi = hi;
    val_lo = lo;
    freeze = frz;
    if (Reset && !rst) begin
      Reset = 1'b0;
      #1;
      checks++;
      if ({en_out, out7, frame_done} !== {8'hFF, 7'h7F, 1'b0}) begin
        failures++;
        $display("FAIL async_reset got=%h/%h/%b exp=ff/7f/0", en_out, out7, frame_done);
      end
    end else begin
      Reset = rst;
    end
    if (!Reset) begin
      t_m = 0;
      snap_m = '0;
      exp_q.push_back({8'hFF, 7'h7F, 1'b0});
    end else begin
      d     = (t_m / DIV) % 8;
      e_en  = ~(8'h01 << d);
      e_seg = exp_seg(snap_m, d);
      e_fd  = (t_m % FRAME) == 0;
      if (e_fd && !frz) snap_m = {hi, lo};
      exp_q.push_back({e_en, e_seg, e_fd});
      t_m++;
    end
  endtask

  logic [15:0] cur_hi = '0;
  logic [15:0] cur_lo = '0;
  logic        cur_frz = 1'b0;

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step(cur_hi, cur_lo, cur_frz, 1'b1);
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < FRAME && (t_m % FRAME) != ph; i++) step(cur_hi, cur_lo, cur_frz, 1'b1);
  endtask

  // monitor / scoreboard
  always begin
    logic [15:0] e;
    @(posedge Clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({en_out, out7, frame_done} !== e) begin
        failures++;
        $display("FAIL out cyc=%0d got=%h/%h/%b exp=%h/%h/%b",
                 cyc, en_out, out7, frame_done, e[15:8], e[7:1], e[0]);
      end
    end
  end

  initial begin
    // reset held with random inputs
    for (int i = 0; i < 10; i++) step(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b0);

    // directed 1234 / ABCD frame, then free run
    cur_hi = 16'h1234;
    cur_lo = 16'hABCD;
    run(2 * FRAME);

    // random values every cycle across five frames: only frame-start values show
    for (int i = 0; i < 5 * FRAME; i++) begin
      cur_hi = 16'($urandom);
      cur_lo = 16'($urandom);
      run(1);
    end

    // val_lo cleared mid-frame at digit 2
    cur_hi = 16'h5A5A;
    cur_lo = 16'h9876;
    run_to_phase(1);
    run_to_phase(2 * DIV);
    cur_lo = 16'h0000;
    run(FRAME + 4);

    // freeze across a frame boundary, change inputs, release mid-frame
    run_to_phase(FRAME - 3);
    cur_frz = 1'b1;
    run(5);
    cur_hi = 16'hBEEF;
    cur_lo = 16'hCAFE;
    run_to_phase(FRAME / 2);
    cur_frz = 1'b0;
    run(FRAME + 4);

    // leading-zero pattern
    cur_hi = 16'h0012;
    cur_lo = 16'h0000;
    run_to_phase(0);
    run(2 * FRAME);

    // asynchronous reset mid-frame, then recover
    run_to_phase(13);
    step(cur_hi, cur_lo, cur_frz, 1'b0);
    for (int i = 0; i < 3; i++) step(cur_hi, cur_lo, cur_frz, 1'b0);
    run(FRAME + 2);

    // random values and freeze
    for (int i = 0; i < 4 * FRAME; i++) begin
      if ($urandom_range(0, 3) == 0) cur_frz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 2) == 0) begin
        cur_hi = 16'($urandom) & {4{4'($urandom_range(0, 1) ? 4'hF : 4'h0)}};
        cur_lo = 16'($urandom) >> (4 * $urandom_range(0, 4));
      end
      run(1);
    end

    repeat (3) @(posedge Clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
